gyro_telemetry_sched: RTL and testbench

Periodic scheduler that sequences the byte-wide UART transmitter for gyro telemetry.
- On each period tick it snapshots the latest x/y/z/temperature samples into a frame.
- The frame is sync, sequence, payload, checksum.
- It feeds the frame byte-by-byte to the UART through a valid/ready handshake.
- It sits between the PmodGYRO outputs and UART_TX, replacing free-running byte rotation with framed, checksummed packets.

---
 rtl/gyro_telemetry_pkg.sv | 18 +
 rtl/gyro_telemetry_sched_if.sv | 11 +
 rtl/period_tick_gen.sv | 22 ++
 rtl/gyro_telemetry_sched.sv | 120 ++++++++++++
 tb/tb_gyro_telemetry_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gyro_telemetry_pkg.sv
// Shared types and constants for the gyro telemetry frame scheduler.
package gyro_telemetry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IDX_W        = 4;
  localparam int FRAME_LEN_T  = 12;
  localparam int FRAME_LEN_NT = 10;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gyro_telemetry_sched_if.sv
// Byte stream from the frame scheduler to the UART transmitter.
// A byte moves on any GCLK edge where tx_valid and tx_ready are both high;
// while tx_valid is high and tx_ready low, tx_data is held unchanged.
interface gyro_telemetry_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/period_tick_gen.sv
// Free-running 0..PERIOD-1 counter; tick is high on the terminal count cycle.
module period_tick_gen #(
  parameter int PERIOD = 1000000
) (
  input  logic GCLK,
  input  logic nRST,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge GCLK or negedge nRST) begin
    if (!nRST)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/gyro_telemetry_sched.sv
// Gyro telemetry framer: snapshots the latest sample set on each period tick
// and streams SYNC0 SYNC1 seq payload chk to the UART over valid/ready.
module gyro_telemetry_sched
  import gyro_telemetry_pkg::*;
#(
  parameter int         PERIOD       = 1000000,
  parameter logic [7:0] SYNC0        = 8'h55,
  parameter logic [7:0] SYNC1        = 8'hAA,
  parameter bit         INCLUDE_TEMP = 1'b1
) (
  input  logic        GCLK,
  input  logic        nRST,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic [15:0] temp_in,
  gyro_telemetry_sched_if.master tx,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  seq,
  output logic [7:0]  overrun_cnt,
  output state_t      dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    INCLUDE_TEMP ? IDX_W'(FRAME_LEN_T - 1) : IDX_W'(FRAME_LEN_NT - 1);

  state_t           state, state_nx;
  logic             tick, start, xfer;
  logic [IDX_W-1:0] idx;
  logic [7:0]       chk, byte_cur;
  logic [15:0]      sh_x, sh_y, sh_z, sh_t;
  logic [15:0]      sn_x, sn_y, sn_z, sn_t;

  period_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .GCLK (GCLK),
    .nRST (nRST),
    .tick (tick)
  );

  assign start = (state == ST_IDLE) && tick && enable;
  assign xfer  = (state == ST_SEND) && tx.tx_ready;

  always_ff @(posedge GCLK or negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    tx.tx_valid = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE: if (tick && enable) state_nx = ST_SEND;
      ST_SEND: begin
        tx.tx_valid = 1'b1;
        busy        = 1'b1;
        if (tx.tx_ready && (idx == LAST_IDX)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // The final index falls through to the running checksum in both frame lengths.
  always_comb begin
    byte_cur = chk;
    case (idx)
      4'd0: byte_cur = SYNC0;
      4'd1: byte_cur = SYNC1;
      4'd2: byte_cur = seq;
      4'd3: byte_cur = sn_x[7:0];
      4'd4: byte_cur = sn_x[15:8];
      4'd5: byte_cur = sn_y[7:0];
      4'd6: byte_cur = sn_y[15:8];
      4'd7: byte_cur = sn_z[7:0];
      4'd8: byte_cur = sn_z[15:8];
      default: byte_cur = chk;
    endcase
    if (INCLUDE_TEMP && (idx == 4'd9))  byte_cur = sn_t[7:0];
    if (INCLUDE_TEMP && (idx == 4'd10)) byte_cur = sn_t[15:8];
  end

  assign tx.tx_data = (state == ST_SEND) ? byte_cur : 8'h00;
  assign dbg_state  = state;

  always_ff @(posedge GCLK or negedge nRST) begin
    if (!nRST) begin
      sh_x <= '0; sh_y <= '0; sh_z <= '0; sh_t <= '0;
      sn_x <= '0; sn_y <= '0; sn_z <= '0; sn_t <= '0;
      idx         <= '0;
      chk         <= '0;
      seq         <= '0;
      overrun_cnt <= '0;
    end else begin
      if (sample_valid) begin
        sh_x <= x_in; sh_y <= y_in; sh_z <= z_in; sh_t <= temp_in;
      end
      // Snapshot reads the shadow before any same-cycle sample update lands.
      if (start) begin
        sn_x <= sh_x; sn_y <= sh_y; sn_z <= sh_z; sn_t <= sh_t;
        idx  <= '0;
        chk  <= '0;
      end else if (xfer) begin
        idx <= idx + 1'b1;
        if ((idx >= IDX_W'(2)) && (idx != LAST_IDX)) chk <= chk + byte_cur;
      end
      if (state == ST_DONE) seq <= seq + 8'd1;
      if (tick && enable && (state != ST_IDLE)) overrun_cnt <= sat_inc8(overrun_cnt);
    end
  end

endmodule

// File: tb/tb_gyro_telemetry_sched.sv
// Directed bench for gyro_telemetry_sched: three instances cover the
// 12-byte frame (slow and fast period) and the 10-byte frame.
module tb_gyro_telemetry_sched;
  import gyro_telemetry_pkg::*;

  // clock / reset
  logic GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  logic        nRST = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] x_in = '0, y_in = '0, z_in = '0, temp_in = '0;
  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic        rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;

  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [7:0] seq_a, seq_b, seq_c, ovr_a, ovr_b, ovr_c;
  state_t     st_a, st_b, st_c;

  gyro_telemetry_sched_if if_a ();
  gyro_telemetry_sched_if if_b ();
  gyro_telemetry_sched_if if_c ();
  assign if_a.tx_ready = rdy_a;
  assign if_b.tx_ready = rdy_b;
  assign if_c.tx_ready = rdy_c;

  gyro_telemetry_sched #(.PERIOD(200), .INCLUDE_TEMP(1'b1)) dut_a (
    .GCLK(GCLK), .nRST(nRST), .enable(en_a), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in), .tx(if_a),
    .busy(busy_a), .frame_done(done_a), .seq(seq_a), .overrun_cnt(ovr_a), .dbg_state(st_a));

  gyro_telemetry_sched #(.PERIOD(16), .INCLUDE_TEMP(1'b1)) dut_b (
    .GCLK(GCLK), .nRST(nRST), .enable(en_b), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in), .tx(if_b),
    .busy(busy_b), .frame_done(done_b), .seq(seq_b), .overrun_cnt(ovr_b), .dbg_state(st_b));

  gyro_telemetry_sched #(.PERIOD(16), .INCLUDE_TEMP(1'b0)) dut_c (
    .GCLK(GCLK), .nRST(nRST), .enable(en_c), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in), .tx(if_c),
    .busy(busy_c), .frame_done(done_c), .seq(seq_c), .overrun_cnt(ovr_c), .dbg_state(st_c));

  // instance selected for observation and driving
  int         sel = 0;
  logic       obs_valid, obs_busy, obs_done;
  logic [7:0] obs_data, obs_seq, obs_ovr;
  state_t     obs_st;

  always_comb begin
    case (sel)
      0: begin obs_valid = if_a.tx_valid; obs_data = if_a.tx_data; obs_busy = busy_a;
               obs_done = done_a; obs_seq = seq_a; obs_ovr = ovr_a; obs_st = st_a; end
      1: begin obs_valid = if_b.tx_valid; obs_data = if_b.tx_data; obs_busy = busy_b;
               obs_done = done_b; obs_seq = seq_b; obs_ovr = ovr_b; obs_st = st_b; end
      default: begin obs_valid = if_c.tx_valid; obs_data = if_c.tx_data; obs_busy = busy_c;
               obs_done = done_c; obs_seq = seq_c; obs_ovr = ovr_c; obs_st = st_c; end
    endcase
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // driver tasks
  task automatic step();
    @(posedge GCLK);
    #1;
  endtask

  task automatic set_ready(input logic v);
    case (sel)
      0: rdy_a = v;
      1: rdy_b = v;
      default: rdy_c = v;
    endcase
  endtask

  task automatic set_en(input logic v);
    case (sel)
      0: en_a = v;
      1: en_b = v;
      default: en_c = v;
    endcase
  endtask

  task automatic do_reset();
    nRST = 1'b0; sample_valid = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    step(); step(); step();
    nRST = 1'b1;
  endtask

  task automatic pulse_sample(input logic [15:0] x, y, z, t);
    sample_valid = 1'b1; x_in = x; y_in = y; z_in = z; temp_in = t;
    step();
    sample_valid = 1'b0;
  endtask

  // Collects n more transferred bytes; mode 0 = ready always, 1 = ready one cycle in four.
  task automatic capture(input int n, input int mode, output bit timed_out, output int unstable);
    int target, cyc;
    bit stalled;
    logic [7:0] held;
    logic r;
    target = got_q.size() + n;
    cyc = 0; stalled = 0; unstable = 0; held = '0;
    while (got_q.size() < target && cyc < 2000) begin
      r = (mode == 0) ? 1'b1 : ((cyc % 4) == 3);
      set_ready(r);
      if (obs_valid) begin
        if (stalled && (obs_data !== held)) unstable++;
        if (r) begin got_q.push_back(obs_data); stalled = 0; end
        else begin stalled = 1; held = obs_data; end
      end else begin
        stalled = 0;
      end
      step();
      cyc++;
    end
    timed_out = (got_q.size() < target);
  endtask

  task automatic load_exp(input logic [95:0] v, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(v[(n-1-i)*8 +: 8]);
  endtask

  // Reference frame built straight from the byte order and checksum definition.
  task automatic load_model(input logic [7:0] s, input logic [15:0] x, y, z, t);
    logic [7:0] b[12];
    logic [7:0] sum;
    b[0] = 8'h55; b[1] = 8'hAA; b[2] = s;
    b[3] = x[7:0]; b[4] = x[15:8]; b[5] = y[7:0]; b[6] = y[15:8];
    b[7] = z[7:0]; b[8] = z[15:8]; b[9] = t[7:0]; b[10] = t[15:8];
    sum = 8'h00;
    for (int k = 2; k < 11; k++) sum = sum + b[k];
    b[11] = sum;
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
  endtask

  function automatic logic [7:0] got_byte(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  // tests
  task automatic test_reset();
    nRST = 1'b0;
    step(); step(); step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      tests_run++; if (obs_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid[%0d]: got %b expected 0", s, obs_valid); end
      tests_run++; if (obs_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data[%0d]: got %h expected 00", s, obs_data); end
      tests_run++; if (obs_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, obs_busy); end
      tests_run++; if (obs_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done[%0d]: got %b expected 0", s, obs_done); end
      tests_run++; if (obs_seq !== 8'h00) begin tests_failed++; $display("FAIL reset_seq[%0d]: got %h expected 00", s, obs_seq); end
      tests_run++; if (obs_ovr !== 8'h00) begin tests_failed++; $display("FAIL reset_ovr[%0d]: got %h expected 00", s, obs_ovr); end
      tests_run++; if (obs_st !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state[%0d]: got %0d expected 0", s, obs_st); end
    end
  endtask

  task automatic test_basic_frame();
    bit to; int un;
    do_reset();
    sel = 0;
    pulse_sample(16'h1234, 16'hABCD, 16'h00FF, 16'h8001);
    set_en(1'b1);
    got_q.delete();
    capture(12, 0, to, un);
    tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout: got %0d bytes expected 12", got_q.size()); end
    load_exp(96'h55AA003412CDABFF0001803E, 12);
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_byte(i), exp_q[i]); end
    end
    tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %b expected 1", obs_done); end
    tests_run++; if (obs_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_done_valid: got %b expected 0", obs_valid); end
    step();
    tests_run++; if (obs_done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_width: got %b expected 0", obs_done); end
    tests_run++; if (obs_seq !== 8'd1) begin tests_failed++; $display("FAIL basic_seq: got %h expected 01", obs_seq); end
  endtask

  task automatic test_stall();
    bit to; int un;
    sel = 0;
    got_q.delete();
    capture(12, 1, to, un);
    tests_run++; if (to) begin tests_failed++; $display("FAIL stall_timeout: got %0d bytes expected 12", got_q.size()); end
    tests_run++; if (un != 0) begin tests_failed++; $display("FAIL stall_stable: got %0d changes expected 0", un); end
    load_exp(96'h55AA013412CDABFF0001803F, 12);
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL stall_byte%0d: got %h expected %h", i, got_byte(i), exp_q[i]); end
    end
    tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL stall_done: got %b expected 1", obs_done); end
    step();
    tests_run++; if (obs_seq !== 8'd2) begin tests_failed++; $display("FAIL stall_seq: got %h expected 02", obs_seq); end
    tests_run++; if (obs_ovr !== 8'd0) begin tests_failed++; $display("FAIL stall_ovr: got %h expected 00", obs_ovr); end
  endtask

  task automatic test_control();
    bit to1, to2; int un, vcount;
    sel = 0;
    got_q.delete();
    capture(5, 0, to1, un);
    set_en(1'b0);
    capture(7, 0, to2, un);
    tests_run++; if (to1 || to2) begin tests_failed++; $display("FAIL ctl_timeout: got %0d bytes expected 12", got_q.size()); end
    load_exp(96'h55AA023412CDABFF00018040, 12);
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL ctl_byte%0d: got %h expected %h", i, got_byte(i), exp_q[i]); end
    end
    tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL ctl_done: got %b expected 1", obs_done); end
    vcount = 0;
    for (int i = 0; i < 450; i++) begin step(); if (obs_valid) vcount++; end
    tests_run++; if (vcount != 0) begin tests_failed++; $display("FAIL ctl_no_frame: got %0d valid cycles expected 0", vcount); end
    tests_run++; if (obs_seq !== 8'd3) begin tests_failed++; $display("FAIL ctl_seq: got %h expected 03", obs_seq); end
    tests_run++; if (obs_ovr !== 8'd0) begin tests_failed++; $display("FAIL ctl_ovr: got %h expected 00", obs_ovr); end

    // reset in the middle of the next frame
    set_en(1'b1);
    got_q.delete();
    capture(3, 0, to1, un);
    tests_run++; if (obs_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_valid: got %b expected 1", obs_valid); end
    nRST = 1'b0;
    #1;
    tests_run++; if (obs_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", obs_valid); end
    tests_run++; if (obs_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h expected 00", obs_data); end
    tests_run++; if (obs_seq !== 8'h00) begin tests_failed++; $display("FAIL rst_seq: got %h expected 00", obs_seq); end
    tests_run++; if (obs_ovr !== 8'h00) begin tests_failed++; $display("FAIL rst_ovr: got %h expected 00", obs_ovr); end
    tests_run++; if (obs_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", obs_busy); end
    step(); step();
    nRST = 1'b1;
    pulse_sample(16'h1234, 16'hABCD, 16'h00FF, 16'h8001);
    got_q.delete();
    capture(12, 0, to1, un);
    load_exp(96'h55AA003412CDABFF0001803E, 12);
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL rst_byte%0d: got %h expected %h", i, got_byte(i), exp_q[i]); end
    end
  endtask

  task automatic test_no_temp();
    bit to; int un;
    do_reset();
    sel = 2;
    pulse_sample(16'h1234, 16'hABCD, 16'h00FF, 16'h8001);
    set_en(1'b1);
    got_q.delete();
    capture(10, 0, to, un);
    tests_run++; if (to) begin tests_failed++; $display("FAIL nt_timeout: got %0d bytes expected 10", got_q.size()); end
    load_exp(96'h55AA003412CDABFF00BD, 10);
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL nt_byte%0d: got %h expected %h", i, got_byte(i), exp_q[i]); end
    end
    tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL nt_done: got %b expected 1", obs_done); end
    tests_run++; if (obs_valid !== 1'b0) begin tests_failed++; $display("FAIL nt_done_valid: got %b expected 0", obs_valid); end
    step();
    tests_run++; if (obs_seq !== 8'd1) begin tests_failed++; $display("FAIL nt_seq: got %h expected 01", obs_seq); end
  endtask

  task automatic test_overrun();
    bit to, seen; int un, un2, vcount;
    logic [7:0] held;
    do_reset();
    sel = 1;
    set_en(1'b1);
    seen = 0; un2 = 0; held = '0;
    // ready low for 40 cycles from reset release; ticks land on cycles 16, 32, 48
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        sample_valid = 1'b1; x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h00FF; temp_in = 16'h8001;
      end else begin
        sample_valid = 1'b0;
      end
      set_ready(1'b0);
      if (obs_valid) begin
        if (seen && (obs_data !== held)) un2++;
        seen = 1; held = obs_data;
      end
      step();
    end
    tests_run++; if (!seen || un2 != 0) begin tests_failed++; $display("FAIL ovr_hold: seen %0d changes %0d expected seen 1 changes 0", seen, un2); end
    got_q.delete();
    capture(12, 0, to, un);
    set_en(1'b0);
    load_exp(96'h55AA003412CDABFF0001803E, 12);
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL ovr_byte%0d: got %h expected %h", i, got_byte(i), exp_q[i]); end
    end
    tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL ovr_done: got %b expected 1", obs_done); end
    step();
    tests_run++; if (obs_seq !== 8'd1) begin tests_failed++; $display("FAIL ovr_seq: got %h expected 01", obs_seq); end
    tests_run++; if (obs_ovr !== 8'd2) begin tests_failed++; $display("FAIL ovr_cnt: got %0d expected 2", obs_ovr); end
    vcount = 0;
    for (int i = 0; i < 40; i++) begin step(); if (obs_valid) vcount++; end
    tests_run++; if (vcount != 0) begin tests_failed++; $display("FAIL ovr_one_frame: got %0d valid cycles expected 0", vcount); end
    tests_run++; if (obs_ovr !== 8'd2) begin tests_failed++; $display("FAIL ovr_cnt_hold: got %0d expected 2", obs_ovr); end
  endtask

  task automatic test_saturation();
    do_reset();
    sel = 1;
    set_en(1'b1);
    set_ready(1'b0);
    repeat (16 + 1600 + 8) step();
    tests_run++; if (obs_ovr !== 8'd100) begin tests_failed++; $display("FAIL sat_mid: got %0d expected 100", obs_ovr); end
    repeat (3200) step();
    tests_run++; if (obs_ovr !== 8'd255) begin tests_failed++; $display("FAIL sat_cap: got %0d expected 255", obs_ovr); end
    tests_run++; if (obs_valid !== 1'b1) begin tests_failed++; $display("FAIL sat_stalled: got %b expected 1", obs_valid); end
  endtask

  task automatic test_seq_wrap_snapshot();
    bit to; int un;
    logic [15:0] mx;
    do_reset();
    sel = 1;
    pulse_sample(16'h1234, 16'hABCD, 16'h00FF, 16'h8001);
    mx = 16'h1234;
    set_en(1'b1);
    for (int f = 0; f < 257; f++) begin
      got_q.delete();
      if (f == 5) begin
        capture(6, 0, to, un);
        sample_valid = 1'b1; x_in = 16'hBEEF;
        capture(1, 0, to, un);
        sample_valid = 1'b0;
        capture(5, 0, to, un);
      end else begin
        capture(12, 0, to, un);
      end
      load_model(8'(f), mx, 16'hABCD, 16'h00FF, 16'h8001);
      for (int i = 0; i < 12; i++) begin
        tests_run++; if (got_byte(i) !== exp_q[i]) begin tests_failed++; $display("FAIL wrap_f%0d_byte%0d: got %h expected %h", f, i, got_byte(i), exp_q[i]); end
      end
      if (f == 5) mx = 16'hBEEF;
      step();
      tests_run++; if (obs_seq !== 8'(f + 1)) begin tests_failed++; $display("FAIL wrap_seq_f%0d: got %h expected %h", f, obs_seq, 8'(f + 1)); end
    end
    tests_run++; if (obs_ovr !== 8'd0) begin tests_failed++; $display("FAIL wrap_ovr: got %0d expected 0", obs_ovr); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_control();
    test_no_temp();
    test_overrun();
    test_saturation();
    test_seq_wrap_snapshot();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
